hazard_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage core: IF, ID, EX, MEM, WB.
- Decides every cycle whether the front end (PC, IF/ID, 4-deep instruction/PC stall chain) advances, holds or is flushed, and whether the whole pipe freezes.
- Handles load-use hazards, taken branches, data-memory wait states and multi-cycle MDU operations.
- Keeps a saturating stall-cycle counter and a sticky MDU timeout error.

---
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush sequencer for the 5-stage core
// Arbitrates load-use, branch flush, data-memory waits and multi-cycle MDU freezes.
module hazard_stall_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             ex_mdu_start,
   input  logic             mdu_done,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             stall_front,
   output logic             bubble_ex,
   output logic             flush_front,
   output logic             stall_all,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mdu_err
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MDU_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             err_q, err_d;
   logic             sf, bx, ff, sa;
   logic             load_use;

   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      sf      = 1'b0;
      bx      = 1'b0;
      ff      = 1'b0;
      sa      = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ack) begin
               sa      = 1'b1;
               state_d = MEM_WAIT;
            end else if (ex_mdu_start) begin
               sa      = 1'b1;
               state_d = MDU_WAIT;
               wcnt_d  = 8'd0;
            end else if (ex_branch_taken) begin
               ff = 1'b1;
            end else if (load_use) begin
               sf = 1'b1;
               bx = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) state_d = RUN;
            else         sa      = 1'b1;
         end
         MDU_WAIT: begin
            wcnt_d = wcnt_q + 8'd1;
            if (mdu_done) begin
               state_d = RUN;
            end else if (wcnt_q == WAIT_LAST) begin
               // Abort: release the pipe and flag the lost result.
               err_d   = 1'b1;
               state_d = RUN;
            end else begin
               sa = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign stall_front  = rst_n & sf;
   assign bubble_ex    = rst_n & bx;
   assign flush_front  = rst_n & ff;
   assign stall_all    = rst_n & sa;
   assign stall_cycles = cyc_q;
   assign mdu_err      = err_q;

   always_comb begin
      cyc_d = cyc_q;
      if ((stall_front || stall_all) && !(&cyc_q))
         cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wcnt_q  <= 8'd0;
         cyc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken;
   logic       ex_mdu_start, mdu_done, mem_req, mem_ack;
   logic       stall_front, bubble_ex, flush_front, stall_all, mdu_err;
   logic [3:0] stall_cycles;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
      .mdu_done(mdu_done), .mem_req(mem_req), .mem_ack(mem_ack),
      .stall_front(stall_front), .bubble_ex(bubble_ex),
      .flush_front(flush_front), .stall_all(stall_all),
      .stall_cycles(stall_cycles), .mdu_err(mdu_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
      ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      clear_in();
      rst_n = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_stall_all", stall_all, 0);
      chk("rst_stall_front", stall_front, 0);
      chk("rst_cycles", stall_cycles, 0);
      chk("rst_err", mdu_err, 0);
      rst_n = 1'b1;
      tick();

      // load-use on rs2
      ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
      #1;
      chk("lu_stall_front", stall_front, 1);
      chk("lu_bubble", bubble_ex, 1);
      chk("lu_stall_all", stall_all, 0);
      chk("lu_flush", flush_front, 0);
      tick();
      clear_in();
      #1;
      chk("lu_release", stall_front, 0);
      chk("lu_cycles", stall_cycles, 1);

      // load-use on rs1, and unused rs1 ignored
      ex_is_load = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1;
      #1;
      chk("lu_rs1", stall_front, 1);
      id_rs1_used = 0;
      #1;
      chk("lu_rs1_unused", stall_front, 0);
      clear_in();

      // x0 load never stalls
      ex_is_load = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1;
      #1;
      chk("x0_stall", stall_front, 0);
      chk("x0_bubble", bubble_ex, 0);
      tick();
      clear_in();
      #1;
      chk("x0_cycles", stall_cycles, 1);

      // branch beats load-use
      ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1; ex_branch_taken = 1;
      #1;
      chk("br_flush", flush_front, 1);
      chk("br_bubble", bubble_ex, 0);
      chk("br_stall_front", stall_front, 0);
      tick();
      clear_in();
      #1;
      chk("br_flush_off", flush_front, 0);
      chk("br_cycles", stall_cycles, 1);

      // memory wait, ack 3 cycles later
      do_reset();
      mem_req = 1;
      #1;
      chk("mw_t0", stall_all, 1);
      tick();
      chk("mw_t1", stall_all, 1);
      tick();
      chk("mw_t2", stall_all, 1);
      tick();
      mem_ack = 1;
      #1;
      chk("mw_ack", stall_all, 0);
      tick();
      clear_in();
      #1;
      chk("mw_cycles", stall_cycles, 3);

      // zero-wait access
      mem_req = 1; mem_ack = 1;
      #1;
      chk("zw_stall", stall_all, 0);
      tick();
      clear_in();
      #1;
      chk("zw_stall_after", stall_all, 0);
      chk("zw_cycles", stall_cycles, 3);

      // MDU, done 5 cycles after start; branch in start cycle suppressed
      do_reset();
      ex_mdu_start = 1; ex_branch_taken = 1;
      #1;
      chk("mdu_t0", stall_all, 1);
      chk("mdu_t0_flush", flush_front, 0);
      tick();
      clear_in();
      for (int i = 1; i < 5; i++) begin
         #1;
         chk($sformatf("mdu_t%0d", i), stall_all, 1);
         tick();
      end
      mdu_done = 1;
      #1;
      chk("mdu_done", stall_all, 0);
      tick();
      clear_in();
      ex_branch_taken = 1;
      #1;
      chk("mdu_run_flush", flush_front, 1);
      chk("mdu_cycles", stall_cycles, 5);
      chk("mdu_err0", mdu_err, 0);
      clear_in();

      // MDU timeout with MDU_TIMEOUT=8
      do_reset();
      ex_mdu_start = 1;
      #1;
      chk("to_t0", stall_all, 1);
      tick();
      clear_in();
      for (int i = 1; i < 8; i++) begin
         #1;
         chk($sformatf("to_t%0d", i), stall_all, 1);
         tick();
      end
      #1;
      chk("to_release", stall_all, 0);
      chk("to_err_pre", mdu_err, 0);
      tick();
      chk("to_err", mdu_err, 1);
      chk("to_after", stall_all, 0);
      mdu_done = 1;
      tick();
      mdu_done = 0;
      tick();
      chk("to_err_sticky", mdu_err, 1);
      chk("to_cycles", stall_cycles, 8);

      // asynchronous reset in the middle of a memory wait
      do_reset();
      #1;
      chk("rm_err_clr", mdu_err, 0);
      mem_req = 1;
      #1;
      chk("rm_stall", stall_all, 1);
      tick();
      tick();
      chk("rm_cycles_pre", stall_cycles, 2);
      #1;
      rst_n = 0;
      #1;
      chk("rm_stall_rst", stall_all, 0);
      chk("rm_cycles_rst", stall_cycles, 0);
      tick();
      rst_n = 1;
      clear_in();
      ex_branch_taken = 1;
      #1;
      chk("rm_run", flush_front, 1);
      chk("rm_stall_after", stall_all, 0);
      clear_in();

      // counter saturation at CNT_W=4
      do_reset();
      mem_req = 1;
      repeat (20) tick();
      chk("sat_stall", stall_all, 1);
      chk("sat_cycles", stall_cycles, 15);
      mem_ack = 1;
      tick();
      clear_in();
      tick();
      chk("sat_hold", stall_cycles, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
